// File: rtl/fetch_ctrl_if.sv
// Fetch-stage bundle: PC feedback, redirect, instruction-memory req/ack and decode valid/ready.
interface fetch_ctrl_if #(
   parameter int AW      = 8,
   parameter int INSTR_W = 32
);
   logic [AW-1:0]      pc_in;
   logic [AW-1:0]      pc_next;
   logic               redirect_valid;
   logic [AW-1:0]      redirect_pc;
   logic               imem_req;
   logic [AW-1:0]      imem_addr;
   logic               imem_ack;
   logic [INSTR_W-1:0] imem_rdata;
   logic               instr_valid;
   logic               instr_ready;
   logic [INSTR_W-1:0] instr_out;
   logic [AW-1:0]      instr_pc;

   modport master (
      input  pc_in, redirect_valid, redirect_pc, imem_ack, imem_rdata, instr_ready,
      output pc_next, imem_req, imem_addr, instr_valid, instr_out, instr_pc
   );

   modport slave (
      output pc_in, redirect_valid, redirect_pc, imem_ack, imem_rdata, instr_ready,
      input  pc_next, imem_req, imem_addr, instr_valid, instr_out, instr_pc
   );
endinterface

// File: rtl/fetch_ctrl.sv
// Fetch control: issues imem requests from the PC, registers the instruction for decode (1 cycle after ack),
// holds it until instr_ready; pc_next is combinational (hold / +4 / redirect), peak one instruction per 2 cycles.
module fetch_ctrl #(
   parameter int instr_MEM_width = 256,
   parameter int INSTR_W         = 32
) (
   input  logic          clk,
   input  logic          rst,
   fetch_ctrl_if.master  bus
);
   localparam int AW = $clog2(instr_MEM_width);
   localparam logic [AW-1:0] PC_STEP = AW'(4);

   typedef enum logic [1:0] {S_IDLE, S_REQ, S_HOLD, S_FLUSH} state_t;

   state_t             state, state_nxt;
   logic               instr_valid_q;
   logic [INSTR_W-1:0] instr_q;
   logic [AW-1:0]      instr_pc_q;
   logic [AW-1:0]      flush_addr;
   logic               ack_in_req;

   assign ack_in_req = (state == S_REQ) && bus.imem_ack;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= S_IDLE;
      else      state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:  state_nxt = S_REQ;
         S_REQ: begin
            if (bus.redirect_valid) state_nxt = bus.imem_ack ? S_REQ : S_FLUSH;
            else if (bus.imem_ack)  state_nxt = S_HOLD;
         end
         S_HOLD: begin
            if (bus.redirect_valid || (instr_valid_q && bus.instr_ready)) state_nxt = S_REQ;
         end
         // A redirect here keeps draining the abandoned request; only its ack releases us.
         S_FLUSH: if (bus.imem_ack) state_nxt = S_REQ;
         default: state_nxt = S_IDLE;
      endcase
   end

   always_comb begin
      bus.imem_req  = (state == S_REQ) || (state == S_FLUSH);
      bus.imem_addr = (state == S_FLUSH) ? flush_addr : bus.pc_in;
      bus.pc_next   = bus.pc_in;
      if (bus.redirect_valid) bus.pc_next = bus.redirect_pc;
      else if (ack_in_req)    bus.pc_next = bus.pc_in + PC_STEP;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         instr_valid_q <= 1'b0;
         instr_q       <= '0;
         instr_pc_q    <= '0;
         flush_addr    <= '0;
      end else begin
         if (bus.redirect_valid) begin
            instr_valid_q <= 1'b0;
         end else if (ack_in_req) begin
            instr_valid_q <= 1'b1;
            instr_q       <= bus.imem_rdata;
            instr_pc_q    <= bus.pc_in;
         end else if ((state == S_HOLD) && instr_valid_q && bus.instr_ready) begin
            instr_valid_q <= 1'b0;
         end
         if ((state == S_REQ) && bus.redirect_valid && !bus.imem_ack) flush_addr <= bus.pc_in;
      end
   end

   assign bus.instr_valid = instr_valid_q;
   assign bus.instr_out   = instr_q;
   assign bus.instr_pc    = instr_pc_q;
endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl: PC register modelled in the loop, scoreboard of expected decode handoffs.
module tb_fetch_ctrl;
   logic clk = 1'b0;
   logic rst = 1'b0;
   int   checks = 0;
   int   errors = 0;

   typedef struct {
      logic [7:0]  pc;
      logic [31:0] data;
   } sb_t;
   sb_t sb[$];

   fetch_ctrl_if #(.AW(8), .INSTR_W(32)) bus ();

   fetch_ctrl #(.instr_MEM_width(256), .INSTR_W(32)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic push(input logic [7:0] pc, input logic [31:0] data);
      sb_t e;
      e.pc   = pc;
      e.data = data;
      sb.push_back(e);
   endtask

   task automatic ack(input logic [31:0] data);
      bus.imem_ack   = 1'b1;
      bus.imem_rdata = data;
   endtask

   task automatic redirect(input logic [7:0] pc);
      bus.redirect_valid = 1'b1;
      bus.redirect_pc    = pc;
   endtask

   // One clock: score any handoff, close the PC register loop, clear single-cycle pulses.
   task automatic tick();
      logic [7:0] nxt;
      sb_t        e;
      nxt = bus.pc_next;
      if (bus.instr_valid && bus.instr_ready && !bus.redirect_valid) begin
         checks++;
         assert (sb.size() != 0) else begin
            errors++;
            $error("FAIL sb_underflow observed=handoff expected=none");
         end
         if (sb.size() != 0) begin
            e = sb.pop_front();
            chk("handoff_instr", bus.instr_out, e.data);
            chk("handoff_pc", 32'(bus.instr_pc), 32'(e.pc));
         end
      end
      @(posedge clk);
      #1;
      bus.pc_in          = nxt;
      bus.imem_ack       = 1'b0;
      bus.redirect_valid = 1'b0;
   endtask

   initial begin
      bus.pc_in          = '0;
      bus.redirect_valid = 1'b0;
      bus.redirect_pc    = '0;
      bus.imem_ack       = 1'b0;
      bus.imem_rdata     = '0;
      bus.instr_ready    = 1'b1;

      repeat (2) @(posedge clk);
      #1;
      chk("rst_req", 32'(bus.imem_req), 32'd0);
      chk("rst_valid", 32'(bus.instr_valid), 32'd0);
      chk("rst_instr_out", bus.instr_out, 32'd0);
      chk("rst_instr_pc", 32'(bus.instr_pc), 32'd0);
      chk("rst_pc_next", 32'(bus.pc_next), 32'd0);
      rst = 1'b1;
      #1;
      chk("idle_req", 32'(bus.imem_req), 32'd0);
      chk("idle_pc_next", 32'(bus.pc_next), 32'd0);
      tick();

      // Zero-wait fetch of 0x00 with decode ready
      #1;
      chk("req0_req", 32'(bus.imem_req), 32'd1);
      chk("req0_addr", 32'(bus.imem_addr), 32'h00);
      ack(32'h2002000A); push(8'h00, 32'h2002000A);
      #1;
      chk("ack0_pc_next", 32'(bus.pc_next), 32'h04);
      tick();
      #1;
      chk("hold0_valid", 32'(bus.instr_valid), 32'd1);
      chk("hold0_instr", bus.instr_out, 32'h2002000A);
      chk("hold0_pc", 32'(bus.instr_pc), 32'h00);
      chk("hold0_req", 32'(bus.imem_req), 32'd0);
      tick();

      // Fetch 0x04 then backpressure for 5 cycles
      #1;
      chk("req4_addr", 32'(bus.imem_addr), 32'h04);
      chk("req4_req", 32'(bus.imem_req), 32'd1);
      ack(32'h11111111); push(8'h04, 32'h11111111);
      bus.instr_ready = 1'b0;
      #1;
      chk("ack4_pc_next", 32'(bus.pc_next), 32'h08);
      tick();
      for (int i = 0; i < 5; i++) begin
         #1;
         chk("bp_valid", 32'(bus.instr_valid), 32'd1);
         chk("bp_instr", bus.instr_out, 32'h11111111);
         chk("bp_pc", 32'(bus.instr_pc), 32'h04);
         chk("bp_req", 32'(bus.imem_req), 32'd0);
         chk("bp_pc_next", 32'(bus.pc_next), 32'h08);
         tick();
      end
      bus.instr_ready = 1'b1;
      #1;
      tick();

      // Fetch 0x08 with ack delayed 3 cycles, redirect to 0x40 one cycle in
      #1;
      chk("req8_req", 32'(bus.imem_req), 32'd1);
      chk("req8_addr", 32'(bus.imem_addr), 32'h08);
      chk("req8_pc_next", 32'(bus.pc_next), 32'h08);
      tick();
      redirect(8'h40);
      #1;
      chk("redir_pc_next", 32'(bus.pc_next), 32'h40);
      chk("redir_addr", 32'(bus.imem_addr), 32'h08);
      tick();
      #1;
      chk("flush_req", 32'(bus.imem_req), 32'd1);
      chk("flush_addr", 32'(bus.imem_addr), 32'h08);
      chk("flush_pc_next", 32'(bus.pc_next), 32'h40);
      tick();
      ack(32'hDEADBEEF);
      #1;
      chk("flush_ack_addr", 32'(bus.imem_addr), 32'h08);
      tick();
      #1;
      chk("flush_drop_valid", 32'(bus.instr_valid), 32'd0);
      chk("req40_req", 32'(bus.imem_req), 32'd1);
      chk("req40_addr", 32'(bus.imem_addr), 32'h40);
      ack(32'h33333333); push(8'h40, 32'h33333333);
      #1;
      chk("ack40_pc_next", 32'(bus.pc_next), 32'h44);
      tick();
      #1;
      tick();

      // Fetch 0x44, then redirect in S_HOLD with ready high drops it
      #1;
      chk("req44_addr", 32'(bus.imem_addr), 32'h44);
      ack(32'h44444444);
      #1;
      tick();
      #1;
      chk("hold44_valid", 32'(bus.instr_valid), 32'd1);
      redirect(8'hFC);
      #1;
      chk("hold_redir_pc_next", 32'(bus.pc_next), 32'hFC);
      tick();

      // Wrap: fetch at 0xFC
      #1;
      chk("hold_redir_drop", 32'(bus.instr_valid), 32'd0);
      chk("reqFC_addr", 32'(bus.imem_addr), 32'hFC);
      ack(32'h55555555); push(8'hFC, 32'h55555555);
      #1;
      chk("wrap_pc_next", 32'(bus.pc_next), 32'h00);
      tick();
      #1;
      chk("wrap_instr_pc", 32'(bus.instr_pc), 32'hFC);
      tick();

      // Redirect coinciding with ack
      #1;
      chk("req00_addr", 32'(bus.imem_addr), 32'h00);
      ack(32'h66666666);
      redirect(8'h80);
      #1;
      chk("ackredir_pc_next", 32'(bus.pc_next), 32'h80);
      tick();
      #1;
      chk("ackredir_valid", 32'(bus.instr_valid), 32'd0);
      chk("req80_req", 32'(bus.imem_req), 32'd1);
      chk("req80_addr", 32'(bus.imem_addr), 32'h80);
      ack(32'h77777777); push(8'h80, 32'h77777777);
      #1;
      tick();
      #1;
      tick();

      chk("sb_drained", 32'(sb.size()), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
